// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: EX/MEM register, load data capture FSM, byte/half alignment
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   stall           pipeline stall vector (bit 3 = MEM, bit 4 = WB)
//   ex_to_mem_bus   {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_load_op      load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU (others behave as LW)
//   data_sram_rdata synchronous SRAM read data for the entry now in this stage
//   mem_to_wb_bus   {pc, rf_we, rf_waddr, mem_result}
//   mem_to_id       forwarding bus {rf_we, rf_waddr, mem_result}
module mem_stage #(
    parameter int EX_TO_MEM_WD = 76,
    parameter int MEM_TO_WB_WD = 70,
    parameter int StallBus     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [2:0]              ex_load_op,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id
);

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LIVE = 2'd1,
        ST_HELD = 2'd2
    } state_e;

    logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
    logic [2:0]              op_q, op_d;
    state_e                  state_q, state_d;
    logic [31:0]             hold_q, hold_d;

    logic bubble;
    logic load_en;
    logic in_is_load;

    // Stall bits outside the MEM/WB pair are not used by this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[StallBus-1:5], stall[2:0]};

    assign bubble     = (stall[3] == Stop) && (stall[4] == NoStop);
    assign load_en    = (stall[3] == NoStop);
    assign in_is_load = ex_to_mem_bus[43] && (ex_to_mem_bus[42:39] == 4'b0000) && ex_to_mem_bus[38];

    always_comb begin
        bus_d   = bus_q;
        op_d    = op_q;
        state_d = state_q;
        hold_d  = hold_q;

        // The SRAM only presents read data for one cycle, so snapshot it while
        // it is live in case the stage is frozen on the next edge.
        if (state_q == ST_LIVE) begin
            hold_d = data_sram_rdata;
        end

        if (bubble) begin
            bus_d   = '0;
            op_d    = '0;
            state_d = ST_IDLE;
        end else if (load_en) begin
            bus_d   = ex_to_mem_bus;
            op_d    = ex_load_op;
            state_d = in_is_load ? ST_LIVE : ST_IDLE;
        end else if (state_q == ST_LIVE) begin
            state_d = ST_HELD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q   <= '0;
            op_q    <= '0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            bus_q   <= bus_d;
            op_q    <= op_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        is_load;

    assign pc           = bus_q[75:44];
    assign data_ram_en  = bus_q[43];
    assign data_ram_wen = bus_q[42:39];
    assign sel_rf_res   = bus_q[38];
    assign rf_we        = bus_q[37];
    assign rf_waddr     = bus_q[36:32];
    assign ex_result    = bus_q[31:0];
    assign is_load      = data_ram_en && (data_ram_wen == 4'b0000) && sel_rf_res;

    logic [31:0] raw_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] mem_result;

    assign raw_word = (state_q == ST_HELD) ? hold_q : data_sram_rdata;

    always_comb begin
        byte_sel = raw_word[7:0];
        case (ex_result[1:0])
            2'd0: byte_sel = raw_word[7:0];
            2'd1: byte_sel = raw_word[15:8];
            2'd2: byte_sel = raw_word[23:16];
            2'd3: byte_sel = raw_word[31:24];
            default: byte_sel = raw_word[7:0];
        endcase
    end

    // Halfword lane follows addr[1] only; addr[0] is ignored.
    assign half_sel = ex_result[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        load_data = raw_word;
        case (op_q)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            default: load_data = raw_word;
        endcase
    end

    assign mem_result = is_load ? load_data : ex_result;

    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, mem_result};
    assign mem_to_id     = {rf_we, rf_waddr, mem_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [75:0] ex_to_mem_bus;
    logic [2:0]  ex_load_op;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id;

    int checks;
    int errors;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_load_op      (ex_load_op),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id       (mem_to_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        en;
        logic [3:0]  wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] rdata;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [75:0] mk_bus(input logic [31:0] pc, input logic en,
                                           input logic [3:0] wen, input logic sel,
                                           input logic we, input logic [4:0] waddr,
                                           input logic [31:0] res);
        return {pc, en, wen, sel, we, waddr, res};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name, input logic [31:0] exp);
        check(name, {38'd0, mem_to_wb_bus[31:0]}, {38'd0, exp});
    endtask

    task automatic check_state_idle(input string name);
        check(name, {68'd0, dut.state_q}, 70'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //                name     pc            en   wen    sel   we    wa     addr          op    rdata         expected
        vecs[0]  = '{"lw",     32'h0000_1000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5,  32'h0000_0100, 3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1]  = '{"lb_b3",  32'h0000_1004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,  32'h0000_0103, 3'd1, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[2]  = '{"lbu_b3", 32'h0000_1008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7,  32'h0000_0103, 3'd2, 32'h80FF_0000, 32'h0000_0080};
        vecs[3]  = '{"lh_h1",  32'h0000_100C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h0000_0102, 3'd3, 32'h80FF_0000, 32'hFFFF_80FF};
        vecs[4]  = '{"lhu_h1", 32'h0000_1010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,  32'h0000_0102, 3'd4, 32'h80FF_0000, 32'h0000_80FF};
        vecs[5]  = '{"lb_b0",  32'h0000_1014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_0100, 3'd1, 32'h1234_567F, 32'h0000_007F};
        vecs[6]  = '{"lb_b1",  32'h0000_1018, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0000_0101, 3'd1, 32'h1122_9933, 32'hFFFF_FF99};
        vecs[7]  = '{"lh_a0",  32'h0000_101C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h0000_0101, 3'd3, 32'h8001_7FFE, 32'h0000_7FFE};
        vecs[8]  = '{"lhu_h0", 32'h0000_1020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h0000_0100, 3'd4, 32'h0000_F00F, 32'h0000_F00F};
        vecs[9]  = '{"op7_lw", 32'h0000_1024, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h0000_0102, 3'd7, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[10] = '{"sw",     32'h0000_1028, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,  32'h0000_0200, 3'd0, 32'h5A5A_5A5A, 32'h0000_0200};
        vecs[11] = '{"alu",    32'h0000_102C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd15, 32'h0000_0055, 3'd0, 32'hFFFF_FFFF, 32'h0000_0055};

        rst             = 1'b1;
        stall           = 6'b0;
        ex_to_mem_bus   = '0;
        ex_load_op      = 3'd0;
        data_sram_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        check("reset_wb", mem_to_wb_bus, 70'd0);
        check("reset_id", {32'd0, mem_to_id}, 70'd0);
        check_state_idle("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            ex_to_mem_bus   = mk_bus(vecs[i].pc, vecs[i].en, vecs[i].wen, vecs[i].sel,
                                     vecs[i].we, vecs[i].waddr, vecs[i].addr);
            ex_load_op      = vecs[i].op;
            stall           = 6'b0;
            data_sram_rdata = $urandom;
            tick();
            data_sram_rdata = vecs[i].rdata;
            ex_to_mem_bus   = '0;
            #1;
            check({vecs[i].name, "_wb"}, mem_to_wb_bus,
                  {vecs[i].pc, vecs[i].we, vecs[i].waddr, vecs[i].exp_res});
            check({vecs[i].name, "_id"}, {32'd0, mem_to_id},
                  {32'd0, vecs[i].we, vecs[i].waddr, vecs[i].exp_res});
            if (vecs[i].wen != 4'h0) begin
                check_state_idle({vecs[i].name, "_state"});
            end
        end

        // Load followed by a three-cycle freeze while the SRAM output drifts.
        ex_to_mem_bus = mk_bus(32'h0000_2000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h0000_0104);
        ex_load_op    = 3'd0;
        tick();
        data_sram_rdata = 32'h1234_5678;
        ex_to_mem_bus   = mk_bus(32'h0000_2004, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h0000_0077);
        #1;
        check_result("hold_live", 32'h1234_5678);
        stall = 6'b011000;
        for (int c = 0; c < 3; c++) begin
            tick();
            data_sram_rdata = 32'hAAAA_AAAA;
            #1;
            check("hold_held", mem_to_wb_bus, {32'h0000_2000, 1'b1, 5'd3, 32'h1234_5678});
        end
        stall = 6'b0;
        #1;
        check_result("hold_release", 32'h1234_5678);
        tick();
        #1;
        check("after_hold_next", mem_to_wb_bus, {32'h0000_2004, 1'b1, 5'd4, 32'h0000_0077});

        // Bubble on an ALU entry clears everything.
        ex_to_mem_bus = mk_bus(32'h0000_2100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h0000_0055);
        stall         = 6'b0;
        tick();
        check("bubble_pre", mem_to_wb_bus, {32'h0000_2100, 1'b1, 5'd9, 32'h0000_0055});
        stall = 6'b001000;
        tick();
        check("bubble_wb", mem_to_wb_bus, 70'd0);
        check("bubble_id", {32'd0, mem_to_id}, 70'd0);
        stall = 6'b0;

        // Reset while a load is held: stale data must not survive.
        ex_to_mem_bus = mk_bus(32'h0000_3000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h0000_0108);
        ex_load_op    = 3'd0;
        tick();
        data_sram_rdata = 32'h1111_1111;
        #1;
        check_result("rst_live", 32'h1111_1111);
        stall = 6'b011000;
        tick();
        data_sram_rdata = 32'h2222_2222;
        #1;
        check_result("rst_held", 32'h1111_1111);
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        stall         = 6'b0;
        ex_to_mem_bus = mk_bus(32'h0000_3004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0000_010C);
        #1;
        check("rst_wb", mem_to_wb_bus, 70'd0);
        check("rst_id", {32'd0, mem_to_id}, 70'd0);
        check_state_idle("rst_state");
        tick();
        data_sram_rdata = 32'h0BAD_F00D;
        ex_to_mem_bus   = '0;
        #1;
        check("rst_fresh_lw", mem_to_wb_bus, {32'h0000_3004, 1'b1, 5'd8, 32'h0BAD_F00D});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Define EX_TO_MEM_WD, default 76, EX-to-MEM bus width.
REQ-002 Define MEM_TO_WB_WD, default 70, MEM-to-WB bus width.
REQ-003 Define StallBus, default 6, stall vector width; Stop = 1'b1, NoStop = 1'b0.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  6  pipeline stall vector; bit 3 = MEM stage, bit 4 = WB stage.
REQ-007 ex_to_mem_bus  input  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-008 ex_load_op  input  3  load type from EX: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; other codes treated as LW.
REQ-009 data_sram_rdata  input  32  synchronous SRAM read data, valid only in the first cycle after the address was issued in EX.
REQ-010 mem_to_wb_bus  output  70  {pc[69:38], rf_we[37], rf_waddr[36:32], mem_result[31:0]}.
REQ-011 mem_to_id  output  38  forwarding bus {rf_we[37], rf_waddr[36:32], mem_result[31:0]}.

Function
REQ-012 The block SHALL hold one pipeline register (76-bit bus plus 3-bit load op) with priority: rst clears; else stall[3]=Stop and stall[4]=NoStop clears (bubble); else stall[3]=NoStop loads inputs; else holds.
REQ-013 A cleared register SHALL present rf_we=0, data_ram_en=0, pc=0, mem_result=0 on both outputs.
REQ-014 The block SHALL decode the registered entry as a load when data_ram_en=1, data_ram_wen=4'b0000 and sel_rf_res=1.
REQ-015 A read-data capture FSM SHALL have states IDLE, LIVE, HELD; reset state IDLE.
REQ-016 IDLE/LIVE/HELD -> LIVE on any register load whose incoming entry is a load; -> IDLE on any load of a non-load entry, bubble clear, or rst.
REQ-017 LIVE -> HELD when the register holds (stall[3]=Stop with stall[4]=Stop); HELD stays HELD while holding.
REQ-018 In LIVE the block SHALL use data_sram_rdata directly and SHALL capture it into a 32-bit hold register on the same edge.
REQ-019 In HELD the block SHALL use the hold register and ignore data_sram_rdata.
REQ-020 Byte lane selection SHALL use ex_result[1:0] little-endian: LB/LBU lane = addr[1:0]; LH/LHU half = addr[1] (addr[0] ignored); LW whole word.
REQ-021 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend.
REQ-022 mem_result SHALL be the aligned load data for loads, else registered ex_result.
REQ-023 rf_we, rf_waddr, pc SHALL pass through unchanged from the register; outputs are combinational from register/FSM/hold state (zero added latency beyond the register).
REQ-024 Stores (data_ram_wen!=0) SHALL forward ex_result and leave the FSM in IDLE.

Reset
REQ-025 On rst=1 at a clock edge, pipeline register, hold register and FSM SHALL clear to zero/IDLE; both output buses read all-zero the following cycle.
REQ-026 Reset asserted while in HELD SHALL discard the held data with no write-back of the stale entry.

Verification
REQ-027 LW addr 0x100, rdata 0xDEADBEEF, no stall -> next cycle mem_result=0xDEADBEEF, rf_we=1, correct waddr.
REQ-028 LB addr 0x103 rdata 0x80FF_0000 -> mem_result=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF; LHU -> 0x000080FF.
REQ-029 LW rdata 0x12345678 then stall[4:3]=11 for 3 cycles while rdata changes to 0xAAAAAAAA -> mem_result stays 0x12345678 throughout and after release.
REQ-030 stall[4:3]=01 on an ALU entry (ex_result 0x55) -> next cycle mem_to_wb_bus=0, mem_to_id rf_we=0.
REQ-031 rst asserted for one cycle while in HELD -> outputs zero next cycle; FSM IDLE; following LW returns fresh rdata.
REQ-032 SW entry, ex_result 0x200 -> mem_result=0x200, rf_we per bus, FSM remains IDLE.
